// File: rtl/axi_switch_drain_pkg.sv
// Shared types for the AXI switch-drain quiesce stage: soft-reg map, AXI channel
// payloads, FSM state and counter sizing.
package axi_switch_drain_pkg;

    localparam int unsigned SR_ADDR_W  = 32;
    localparam int unsigned SR_DATA_W  = 64;
    localparam int unsigned AXI_ID_W   = 4;
    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_DATA_W = 64;
    localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

    // Soft-register address map
    localparam logic [SR_ADDR_W-1:0] SR_ADDR_ID        = 32'h00;
    localparam logic [SR_ADDR_W-1:0] SR_ADDR_SCRATCH   = 32'h08;
    localparam logic [SR_ADDR_W-1:0] SR_ADDR_MUX_SEL   = 32'h10;
    localparam logic [SR_ADDR_W-1:0] SR_ADDR_DRAIN_REQ = 32'h18;

    typedef enum logic [1:0] {
        ST_PASS,
        ST_DRAIN,
        ST_ISSUE,
        ST_SETTLE
    } axi_drain_state_t;

    typedef struct packed {
        logic                 valid;
        logic                 is_write;
        logic [SR_ADDR_W-1:0] addr;
        logic [SR_DATA_W-1:0] data;
    } soft_reg_req_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } axi_ax_t;

    // Master-to-slave direction: address/write channels plus response readies
    typedef struct packed {
        logic                  ar_valid;
        axi_ax_t               ar;
        logic                  aw_valid;
        axi_ax_t               aw;
        logic                  w_valid;
        logic [AXI_DATA_W-1:0] w_data;
        logic [AXI_STRB_W-1:0] w_strb;
        logic                  w_last;
        logic                  r_ready;
        logic                  b_ready;
    } axi_req_t;

    // Slave-to-master direction: channel readies plus read/write responses
    typedef struct packed {
        logic                  ar_ready;
        logic                  aw_ready;
        logic                  w_ready;
        logic                  r_valid;
        logic [AXI_ID_W-1:0]   r_id;
        logic [AXI_DATA_W-1:0] r_data;
        logic [1:0]            r_resp;
        logic                  r_last;
        logic                  b_valid;
        logic [AXI_ID_W-1:0]   b_id;
        logic [1:0]            b_resp;
    } axi_rsp_t;

    function automatic int unsigned ctr_width(input int unsigned max_out);
        return $clog2(max_out) + 1;
    endfunction

endpackage

// File: rtl/axi_switch_drain_outstanding_ctr.sv
// Up/down outstanding-burst counter; holds at zero on underflow and at MAX_OUT on overflow.
module outstanding_ctr
    import axi_switch_drain_pkg::*;
#(
    parameter int unsigned MAX_OUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_at_max_c,
    output logic o_is_zero_c
);

    localparam int unsigned W = ctr_width(MAX_OUT);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && !i_dec && !o_at_max_c) begin
            r_count <= r_count + W'(1);
        end else if (i_dec && !i_inc && !o_is_zero_c) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_at_max_c  = (r_count == W'(MAX_OUT));
    assign o_is_zero_c = (r_count == '0);

    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(i_dec && !i_inc && o_is_zero_c));

endmodule

// File: rtl/axi_switch_drain.sv
// Quiesces AXI traffic ahead of the 2x2 steering mux, then commits a new select
// through the mux soft register once nothing is in flight.
module axi_switch_drain
    import axi_switch_drain_pkg::*;
#(
    parameter logic [SR_ADDR_W-1:0] SR_ADDR       = SR_ADDR_DRAIN_REQ,
    parameter logic [SR_ADDR_W-1:0] MUX_SR_ADDR   = SR_ADDR_MUX_SEL,
    parameter int unsigned          MAX_OUT       = 64,
    parameter int unsigned          SETTLE_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  soft_reg_req_t sr_req,
    output soft_reg_req_t sr_out,
    input  axi_req_t      axi_m_req,
    output axi_rsp_t      axi_m_rsp,
    output axi_req_t      axi_s_req,
    input  axi_rsp_t      axi_s_rsp,
    output logic          busy,
    output logic          sel
);

    localparam int unsigned CRED_W = ctr_width(MAX_OUT) + 1;
    localparam int unsigned SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    axi_drain_state_t   r_state;
    logic               r_req_sel;
    logic               r_pend;
    logic               r_sel;
    logic               r_busy;
    logic               r_w_mid;
    logic signed [CRED_W-1:0] r_wcred;
    logic [SET_W-1:0]   r_settle;
    soft_reg_req_t      r_sr_out;

    logic w_req, w_next_sel, w_drained;
    logic w_rd_at_max, w_rd_zero, w_wr_at_max, w_wr_zero;
    logic w_blk_ar, w_blk_aw, w_blk_w;
    logic w_ar_hs, w_aw_hs, w_w_hs, w_wlast_hs, w_rlast_hs, w_b_hs;
    logic w_cred_neg, w_cred_pos;
    logic w_unused_sr_data;

    assign w_req      = sr_req.valid && sr_req.is_write && (sr_req.addr == SR_ADDR);
    assign w_next_sel = w_req ? sr_req.data[0] : r_req_sel;
    assign w_unused_sr_data = ^sr_req.data[SR_DATA_W-1:1];

    assign w_cred_neg = r_wcred[CRED_W-1];
    assign w_cred_pos = !r_wcred[CRED_W-1] && (r_wcred != '0);
    assign w_drained  = w_rd_zero && w_wr_zero && (r_wcred == '0) && !r_w_mid;

    // Channel gating: saturation always applies, drain rules outside PASS
    always_comb begin
        w_blk_ar = w_rd_at_max || (r_state != ST_PASS);
        w_blk_aw = w_wr_at_max;
        w_blk_w  = 1'b0;
        case (r_state)
            ST_DRAIN: begin
                if (!w_cred_neg)              w_blk_aw = 1'b1;
                if (!r_w_mid && !w_cred_pos)  w_blk_w  = 1'b1;
            end
            ST_ISSUE, ST_SETTLE: begin
                w_blk_aw = 1'b1;
                w_blk_w  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        axi_s_req          = axi_m_req;
        axi_s_req.ar_valid = axi_m_req.ar_valid && !w_blk_ar;
        axi_s_req.aw_valid = axi_m_req.aw_valid && !w_blk_aw;
        axi_s_req.w_valid  = axi_m_req.w_valid  && !w_blk_w;
        axi_m_rsp          = axi_s_rsp;
        axi_m_rsp.ar_ready = axi_s_rsp.ar_ready && !w_blk_ar;
        axi_m_rsp.aw_ready = axi_s_rsp.aw_ready && !w_blk_aw;
        axi_m_rsp.w_ready  = axi_s_rsp.w_ready  && !w_blk_w;
    end

    assign w_ar_hs    = axi_s_req.ar_valid && axi_s_rsp.ar_ready;
    assign w_aw_hs    = axi_s_req.aw_valid && axi_s_rsp.aw_ready;
    assign w_w_hs     = axi_s_req.w_valid  && axi_s_rsp.w_ready;
    assign w_wlast_hs = w_w_hs && axi_s_req.w_last;
    assign w_rlast_hs = axi_s_rsp.r_valid && axi_m_req.r_ready && axi_s_rsp.r_last;
    assign w_b_hs     = axi_s_rsp.b_valid && axi_m_req.b_ready;

    outstanding_ctr #(.MAX_OUT(MAX_OUT)) u_rd_ctr (
        .clk         (clk),
        .rst         (rst),
        .i_inc       (w_ar_hs),
        .i_dec       (w_rlast_hs),
        .o_at_max_c  (w_rd_at_max),
        .o_is_zero_c (w_rd_zero)
    );

    outstanding_ctr #(.MAX_OUT(MAX_OUT)) u_wr_ctr (
        .clk         (clk),
        .rst         (rst),
        .i_inc       (w_aw_hs),
        .i_dec       (w_b_hs),
        .o_at_max_c  (w_wr_at_max),
        .o_is_zero_c (w_wr_zero)
    );

    // Write-data credit (AW minus completed W bursts) and mid-burst tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wcred <= '0;
            r_w_mid <= 1'b0;
        end else begin
            if (w_aw_hs && !w_wlast_hs)      r_wcred <= r_wcred + CRED_W'(1);
            else if (!w_aw_hs && w_wlast_hs) r_wcred <= r_wcred - CRED_W'(1);
            if (w_w_hs)                      r_w_mid <= !axi_s_req.w_last;
        end
    end

    // Switch FSM; the select value is captured into sr_out on DRAIN exit so a
    // request landing in that same cycle still wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_PASS;
            r_req_sel <= 1'b1;
            r_pend    <= 1'b0;
            r_sel     <= 1'b1;
            r_busy    <= 1'b0;
            r_settle  <= '0;
            r_sr_out  <= '0;
        end else begin
            r_sr_out <= '0;
            if (w_req) begin
                r_req_sel <= sr_req.data[0];
                r_pend    <= 1'b1;
            end
            case (r_state)
                ST_PASS: begin
                    if (w_req) begin
                        r_state <= ST_DRAIN;
                        r_busy  <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (w_drained) begin
                        r_state           <= ST_ISSUE;
                        r_pend            <= 1'b0;
                        r_sr_out.valid    <= 1'b1;
                        r_sr_out.is_write <= 1'b1;
                        r_sr_out.addr     <= MUX_SR_ADDR;
                        r_sr_out.data     <= SR_DATA_W'(w_next_sel);
                    end
                end
                ST_ISSUE: begin
                    r_sel    <= r_sr_out.data[0];
                    r_state  <= ST_SETTLE;
                    r_settle <= SET_W'(SETTLE_CYCLES - 1);
                end
                ST_SETTLE: begin
                    if (r_settle == '0) begin
                        if (r_pend || w_req) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_state <= ST_PASS;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_settle <= r_settle - SET_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_PASS;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign sr_out = r_sr_out;
    assign busy   = r_busy;
    assign sel    = r_sel;

endmodule

// File: tb/tb_axi_switch_drain.sv
// Directed bench for axi_switch_drain: idle switch, read/write drain, saturation,
// back-to-back requests and reset mid-drain.
module tb_axi_switch_drain;
    import axi_switch_drain_pkg::*;

    localparam logic [31:0] REQ_ADDR = 32'h18;
    localparam logic [31:0] MUX_ADDR = 32'h10;
    localparam logic [31:0] OTH_ADDR = 32'h08;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    soft_reg_req_t sr_req, sr_out;
    axi_req_t      axi_m_req, axi_s_req;
    axi_rsp_t      axi_m_rsp, axi_s_rsp;
    logic          busy, sel;

    int n_chk = 0;
    int n_pass = 0;
    int n_ar_hs = 0;
    int n_pulse = 0;
    int p0, n0;

    axi_switch_drain #(
        .SR_ADDR       (32'h18),
        .MUX_SR_ADDR   (32'h10),
        .MAX_OUT       (64),
        .SETTLE_CYCLES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sr_req    (sr_req),
        .sr_out    (sr_out),
        .axi_m_req (axi_m_req),
        .axi_m_rsp (axi_m_rsp),
        .axi_s_req (axi_s_req),
        .axi_s_rsp (axi_s_rsp),
        .busy      (busy),
        .sel       (sel)
    );

    always #5 clk = ~clk;

    // Mid-cycle monitors: AR admitted toward the mux, and sr_out pulses
    always @(negedge clk) begin
        if (!rst && axi_s_req.ar_valid && axi_s_rsp.ar_ready) n_ar_hs++;
        if (sr_out.valid) n_pulse++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic sr_write(input logic [31:0] a, input logic [63:0] d, input logic wr);
        sr_req.valid    = 1'b1;
        sr_req.is_write = wr;
        sr_req.addr     = a;
        sr_req.data     = d;
        cyc(1);
        sr_req = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sr_req              = '0;
        axi_m_req           = '0;
        axi_m_req.r_ready   = 1'b1;
        axi_m_req.b_ready   = 1'b1;
        axi_m_req.ar.len    = 8'd7;
        axi_m_req.aw.len    = 8'd3;
        axi_s_rsp           = '0;
        axi_s_rsp.ar_ready  = 1'b1;
        axi_s_rsp.aw_ready  = 1'b1;
        axi_s_rsp.w_ready   = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(1); #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_sel", 64'(sel), 64'd1);
        chk("rst_sr_valid", 64'(sr_out.valid), 64'd0);
        chk("rst_sr_data", sr_out.data, 64'd0);
        chk("rst_arready", 64'(axi_m_rsp.ar_ready), 64'd1);

        // Ignored accesses: read of the request address, write elsewhere
        sr_write(REQ_ADDR, 64'd0, 1'b0); #1;
        chk("ign_read_busy", 64'(busy), 64'd0);
        sr_write(OTH_ADDR, 64'd0, 1'b1); #1;
        chk("ign_addr_busy", 64'(busy), 64'd0);

        // Idle switch to 0
        p0 = n_pulse;
        sr_write(REQ_ADDR, 64'd0, 1'b1); #1;
        chk("idle_busy_rise", 64'(busy), 64'd1);
        chk("idle_sr_early", 64'(sr_out.valid), 64'd0);
        cyc(1); #1;
        chk("idle_sr_valid", 64'(sr_out.valid), 64'd1);
        chk("idle_sr_wr", 64'(sr_out.is_write), 64'd1);
        chk("idle_sr_addr", 64'(sr_out.addr), 64'(MUX_ADDR));
        chk("idle_sr_data", sr_out.data, 64'd0);
        cyc(1); #1;
        chk("idle_sel", 64'(sel), 64'd0);
        chk("idle_sr_drop", 64'(sr_out.valid), 64'd0);
        chk("idle_settle1", 64'(busy), 64'd1);
        cyc(1); #1;
        chk("idle_settle2", 64'(busy), 64'd1);
        cyc(1); #1;
        chk("idle_busy_fall", 64'(busy), 64'd0);
        chk("idle_pulses", 64'(n_pulse - p0), 64'd1);

        // Read drain: 3 bursts outstanding, switch to 1
        n0 = n_ar_hs;
        axi_m_req.ar_valid = 1'b1;
        cyc(3);
        axi_m_req.ar_valid = 1'b0;
        sr_write(REQ_ADDR, 64'd1, 1'b1);
        axi_m_req.ar_valid = 1'b1; #1;
        chk("rd_ar_gated", 64'(axi_s_req.ar_valid), 64'd0);
        chk("rd_arready_gated", 64'(axi_m_rsp.ar_ready), 64'd0);
        p0 = n_pulse;
        axi_s_rsp.r_valid = 1'b1;
        axi_s_rsp.r_last  = 1'b0; #1;
        chk("rd_r_pass", 64'(axi_m_rsp.r_valid), 64'd1);
        cyc(1);
        axi_s_rsp.r_last = 1'b1;
        cyc(2);
        axi_s_rsp.r_valid = 1'b0;
        axi_s_rsp.r_last  = 1'b0;
        cyc(2); #1;
        chk("rd_no_sr_2of3", 64'(n_pulse - p0), 64'd0);
        axi_s_rsp.r_valid = 1'b1;
        axi_s_rsp.r_last  = 1'b1;
        cyc(1);
        axi_s_rsp.r_valid = 1'b0;
        axi_s_rsp.r_last  = 1'b0; #1;
        chk("rd_sr_not_yet", 64'(sr_out.valid), 64'd0);
        cyc(1); #1;
        chk("rd_sr_valid", 64'(sr_out.valid), 64'd1);
        chk("rd_sr_data", sr_out.data, 64'd1);
        chk("rd_ar_count", 64'(n_ar_hs - n0), 64'd3);
        axi_m_req.ar_valid = 1'b0;
        cyc(3); #1;
        chk("rd_busy_fall", 64'(busy), 64'd0);
        chk("rd_sel", 64'(sel), 64'd1);

        // Write ordering: W burst ahead of its AW, switch to 0 mid-burst
        p0 = n_pulse;
        axi_m_req.w_valid = 1'b1;
        axi_m_req.w_last  = 1'b0;
        cyc(1);
        sr_req.valid    = 1'b1;
        sr_req.is_write = 1'b1;
        sr_req.addr     = REQ_ADDR;
        sr_req.data     = 64'd0;
        cyc(1);
        sr_req = '0; #1;
        chk("wr_mid_wvalid", 64'(axi_s_req.w_valid), 64'd1);
        chk("wr_mid_wready", 64'(axi_m_rsp.w_ready), 64'd1);
        cyc(1);
        axi_m_req.w_last = 1'b1; #1;
        chk("wr_last_wvalid", 64'(axi_s_req.w_valid), 64'd1);
        cyc(1);
        axi_m_req.w_valid  = 1'b0;
        axi_m_req.w_last   = 1'b0;
        axi_m_req.aw_valid = 1'b1; #1;
        chk("wr_aw_admit", 64'(axi_s_req.aw_valid), 64'd1);
        chk("wr_awready", 64'(axi_m_rsp.aw_ready), 64'd1);
        cyc(1);
        axi_m_req.w_valid = 1'b1; #1;
        chk("wr_aw_blocked", 64'(axi_s_req.aw_valid), 64'd0);
        chk("wr_wstart_blocked", 64'(axi_s_req.w_valid), 64'd0);
        chk("wr_wready_blocked", 64'(axi_m_rsp.w_ready), 64'd0);
        cyc(2);
        axi_m_req.aw_valid = 1'b0;
        axi_m_req.w_valid  = 1'b0; #1;
        chk("wr_no_sr_before_b", 64'(n_pulse - p0), 64'd0);
        chk("wr_busy", 64'(busy), 64'd1);
        axi_s_rsp.b_valid = 1'b1; #1;
        chk("wr_b_pass", 64'(axi_m_rsp.b_valid), 64'd1);
        cyc(1);
        axi_s_rsp.b_valid = 1'b0; #1;
        chk("wr_sr_not_yet", 64'(sr_out.valid), 64'd0);
        cyc(1); #1;
        chk("wr_sr_valid", 64'(sr_out.valid), 64'd1);
        chk("wr_sr_data", sr_out.data, 64'd0);
        cyc(3); #1;
        chk("wr_busy_fall", 64'(busy), 64'd0);
        chk("wr_sel", 64'(sel), 64'd0);

        // Saturation: 64 reads accepted, none returned
        n0 = n_ar_hs;
        axi_m_req.ar_valid = 1'b1;
        cyc(64); #1;
        chk("sat_count", 64'(n_ar_hs - n0), 64'd64);
        chk("sat_arready", 64'(axi_m_rsp.ar_ready), 64'd0);
        chk("sat_arvalid", 64'(axi_s_req.ar_valid), 64'd0);
        cyc(2); #1;
        chk("sat_hold", 64'(n_ar_hs - n0), 64'd64);
        axi_s_rsp.r_valid = 1'b1;
        axi_s_rsp.r_last  = 1'b1; #1;
        chk("sat_rlast_cycle", 64'(axi_m_rsp.ar_ready), 64'd0);
        cyc(1);
        axi_s_rsp.r_valid = 1'b0; #1;
        chk("sat_reassert", 64'(axi_m_rsp.ar_ready), 64'd1);
        axi_m_req.ar_valid = 1'b0;
        axi_s_rsp.r_valid  = 1'b1;
        cyc(63);
        axi_s_rsp.r_valid = 1'b0;
        axi_s_rsp.r_last  = 1'b0; #1;
        chk("sat_final_count", 64'(n_ar_hs - n0), 64'd64);

        // Back-to-back requests during DRAIN, then one during SETTLE
        axi_m_req.ar_valid = 1'b1;
        cyc(1);
        axi_m_req.ar_valid = 1'b0;
        p0 = n_pulse;
        sr_write(REQ_ADDR, 64'd0, 1'b1);
        sr_write(REQ_ADDR, 64'd1, 1'b1); #1;
        chk("b2b_busy", 64'(busy), 64'd1);
        chk("b2b_sr_early", 64'(sr_out.valid), 64'd0);
        axi_s_rsp.r_valid = 1'b1;
        axi_s_rsp.r_last  = 1'b1;
        cyc(1);
        axi_s_rsp.r_valid = 1'b0;
        axi_s_rsp.r_last  = 1'b0;
        cyc(1); #1;
        chk("b2b_sr_valid", 64'(sr_out.valid), 64'd1);
        chk("b2b_sr_data", sr_out.data, 64'd1);
        cyc(1); #1;
        chk("b2b_sel", 64'(sel), 64'd1);
        sr_write(REQ_ADDR, 64'd0, 1'b1); #1;
        chk("b2b_single_pulse", 64'(n_pulse - p0), 64'd1);
        cyc(1); #1;
        chk("b2b_redrain_busy", 64'(busy), 64'd1);
        chk("b2b_redrain_sr", 64'(sr_out.valid), 64'd0);
        cyc(1); #1;
        chk("b2b_sr2_valid", 64'(sr_out.valid), 64'd1);
        chk("b2b_sr2_data", sr_out.data, 64'd0);
        cyc(4); #1;
        chk("b2b_busy_fall", 64'(busy), 64'd0);
        chk("b2b_sel_final", 64'(sel), 64'd0);
        chk("b2b_pulses", 64'(n_pulse - p0), 64'd2);

        // Reset mid-DRAIN with 2 reads outstanding
        axi_m_req.ar_valid = 1'b1;
        cyc(2);
        axi_m_req.ar_valid = 1'b0;
        sr_write(REQ_ADDR, 64'd1, 1'b1); #1;
        chk("rstd_busy", 64'(busy), 64'd1);
        p0 = n_pulse;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0; #1;
        chk("rstd_busy_clr", 64'(busy), 64'd0);
        chk("rstd_sel", 64'(sel), 64'd1);
        chk("rstd_sr", 64'(sr_out.valid), 64'd0);
        cyc(3); #1;
        chk("rstd_no_pulse", 64'(n_pulse - p0), 64'd0);
        chk("rstd_arready", 64'(axi_m_rsp.ar_ready), 64'd1);
        sr_write(REQ_ADDR, 64'd0, 1'b1);
        cyc(1); #1;
        chk("rstd_ctr_zero_sr", 64'(sr_out.valid), 64'd1);
        chk("rstd_ctr_zero_data", sr_out.data, 64'd0);
        cyc(4); #1;
        chk("rstd_busy_end", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
